// File: rtl/memory_arbiter_pkg.sv
// Shared state encoding, LED width and address-decode rule for memory_arbiter.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        PERIPH  = 2'd2,
        RESPOND = 2'd3
    } arbState_e;

    localparam int LED_WIDTH = 6;

    // A set address MSB selects the LED peripheral; everything else goes to memory.
    function automatic logic isPeriphAddress(input logic addrMsb);
        return addrMsb;
    endfunction

    function automatic int indexWidth(input int numPorts);
        return (numPorts > 1) ? $clog2(numPorts) : 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr.sv
// Combinational round-robin grant: searches from the port after lastGrant, wrapping once.
module rr_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]                 reqVec_i,
    input  logic [indexWidth(NUM_PORTS)-1:0]     lastGrant_i,
    output logic [NUM_PORTS-1:0]                 grantOneHot_o,
    output logic [indexWidth(NUM_PORTS)-1:0]     grantIndex_o,
    output logic                                 grantValid_o
);

    localparam int IDX_W = indexWidth(NUM_PORTS);

    logic [IDX_W-1:0] candidate;

    always_comb begin
        grantOneHot_o = '0;
        grantIndex_o  = '0;
        grantValid_o  = 1'b0;
        candidate     = '0;
        for (int offset = 1; offset <= NUM_PORTS; offset++) begin
            candidate = IDX_W'((int'(lastGrant_i) + offset) % NUM_PORTS);
            if (!grantValid_o && reqVec_i[candidate]) begin
                grantValid_o             = 1'b1;
                grantIndex_o             = candidate;
                grantOneHot_o[candidate] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port and an LED peripheral between requesters.
// Define MEMORY_ARBITER_TIMEOUT_EN to abort stalled memory accesses after TIMEOUT_CYCLES.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            reqValid,
    input  logic [NUM_PORTS-1:0]            reqWrite,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] reqAddress,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] reqData,
    output logic [NUM_PORTS-1:0]            respValid,
    output logic [DATA_WIDTH-1:0]           respData,
    output logic                            respError,
    output logic                            memReadEnable,
    output logic                            memWriteEnable,
    output logic [ADDR_WIDTH-1:0]           memAddress,
    output logic [DATA_WIDTH-1:0]           memDataOut,
    input  logic [DATA_WIDTH-1:0]           memDataIn,
    input  logic                            memReady,
    output logic [LED_WIDTH-1:0]            led
);

    localparam int IDX_W = indexWidth(NUM_PORTS);

    arbState_e             state_q, state_d;
    logic [IDX_W-1:0]      lastGrant_q, lastGrant_d;
    logic [NUM_PORTS-1:0]  grantVec_q, grantVec_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  err_q, err_d;
`endif

    logic [NUM_PORTS-1:0]  grantOneHot;
    logic [IDX_W-1:0]      grantIdx;
    logic                  grantValid;

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS)
    ) u_rrArbiter (
        .reqVec_i     (reqValid),
        .lastGrant_i  (lastGrant_q),
        .grantOneHot_o(grantOneHot),
        .grantIndex_o (grantIdx),
        .grantValid_o (grantValid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lastGrant_q <= IDX_W'(NUM_PORTS - 1);
            grantVec_q  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            led_q       <= '0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
            timer_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            grantVec_q  <= grantVec_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            led_q       <= led_d;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
            timer_q     <= timer_d;
            err_q       <= err_d;
`endif
        end
    end

    // The whole request is latched at grant so a requester dropping reqValid cannot disturb it.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grantVec_d  = grantVec_q;
        addr_d      = addr_q;
        data_d      = data_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        led_d       = led_q;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        timer_d     = timer_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    lastGrant_d = grantIdx;
                    grantVec_d  = grantOneHot;
                    addr_d      = reqAddress[int'(grantIdx) * ADDR_WIDTH +: ADDR_WIDTH];
                    data_d      = reqData[int'(grantIdx) * DATA_WIDTH +: DATA_WIDTH];
                    write_d     = reqWrite[grantIdx];
                    state_d     = isPeriphAddress(addr_d[ADDR_WIDTH-1]) ? PERIPH : ISSUE;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
                    timer_d     = '0;
                    err_d       = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (memReady) begin
                    rdata_d = write_q ? '0 : memDataIn;
                    state_d = RESPOND;
                end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
                else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            PERIPH: begin
                if (write_q) begin
                    led_d   = data_q[LED_WIDTH-1:0];
                    rdata_d = '0;
                end else begin
                    rdata_d = DATA_WIDTH'(led_q);
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        respValid      = '0;
        memReadEnable  = 1'b0;
        memWriteEnable = 1'b0;
        if (state_q == RESPOND) begin
            respValid = grantVec_q;
        end
        if (state_q == ISSUE) begin
            memReadEnable  = !write_q;
            memWriteEnable = write_q;
        end
    end

    assign respData   = rdata_q;
    assign memAddress = addr_q;
    assign memDataOut = data_q;
    assign led        = led_q;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    assign respError  = err_q;
`else
    assign respError  = 1'b0;
`endif

endmodule
